button_conditioner: RTL

Conditions the raw Basys3 push-buttons before they reach the ALU controller. Each button is synchronised, debounced with a per-button stability counter, and converted to a single-cycle rising-edge pulse. The pulses drive the controller's load strobes for operand A, operand B and opcode, so one physical press latches exactly once.

---
 rtl/alu_pkg.sv | 18 +
 rtl/debounce_cell.sv | 58 +++++
 rtl/button_conditioner.sv | 51 +++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU front end and button conditioner
package alu_pkg;

    localparam int DEFAULT_N_PULSADORES    = 3;
    localparam int CLOCK_FREQ_HZ           = 100_000_000;
    localparam int DEBOUNCE_TIME_MS        = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLOCK_FREQ_HZ / 1000) * DEBOUNCE_TIME_MS;

    localparam int BTN_LOAD_A  = 0;
    localparam int BTN_LOAD_B  = 1;
    localparam int BTN_LOAD_OP = 2;

    // A debounce of one cycle still needs a one-bit counter.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - one button: two-flop synchroniser, stability counter,
// accepted level and combinational rising-commit pulse
module debounce_cell
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        sync1_d  = i_btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        count_d  = '0;
        o_rise   = 1'b0;
        // Any matching cycle drops the count back to zero, so only an
        // unbroken run of DEBOUNCE_CYCLES mismatches is accepted.
        if (sync2_q != stable_q) begin
            if (count_q == CNT_MAX) begin
                stable_d = sync2_q;
                o_rise   = sync2_q;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            count_q  <= count_d;
        end
    end

    assign o_level = stable_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced levels and one-cycle press pulses for the
// ALU load buttons; BTN_ONEHOT_EN keeps only the lowest simultaneous press
module button_conditioner
    import alu_pkg::*;
#(
    parameter int N_PULSADORES    = DEFAULT_N_PULSADORES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [N_PULSADORES-1:0] i_pulsadores,
    output logic [N_PULSADORES-1:0] o_pulsadores,
    output logic [N_PULSADORES-1:0] o_level
);

    logic [N_PULSADORES-1:0] raw_pulse;
    logic [N_PULSADORES-1:0] pulse_q, pulse_d;

    for (genvar g = 0; g < N_PULSADORES; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_btn   (i_pulsadores[g]),
            .o_level (o_level[g]),
            .o_rise  (raw_pulse[g])
        );
    end

    always_comb begin
        pulse_d = '0;
`ifdef BTN_ONEHOT_EN
        // Two's-complement trick isolates the lowest set bit; others are dropped.
        pulse_d = raw_pulse & (~raw_pulse + N_PULSADORES'(1));
`else
        pulse_d = raw_pulse;
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign o_pulsadores = pulse_q;

endmodule
